// File: rtl/edge_adder_pkg.sv
// Shared definitions for the edge adder controller: command encodings, FSM states
// and the legal-command check used when an op is popped.
package edge_adder_pkg;

  localparam logic [2:0] CMD_ADD   = 3'b010;
  localparam logic [2:0] CMD_VN_L  = 3'b011;
  localparam logic [2:0] CMD_VN_R  = 3'b100;
  localparam logic [2:0] CMD_VN_LR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HOLD,
    ST_WAIT,
    ST_CAPT
  } state_e;

  function automatic logic is_legal_cmd(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_VN_L) || (cmd == CMD_VN_R) || (cmd == CMD_VN_LR);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; exposes the head entry and occupancy.
// Storage is cleared on reset so the head reads as zero while empty after reset.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q;
  logic [AW:0]  rdPtr_q;
  logic         empty;
  logic         full;

  assign empty   = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full) begin
        mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        wrPtr_q                <= wrPtr_q + 1'b1;
      end
      if (pop_i && !empty) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

endmodule

// File: rtl/edge_adder_ctrl.sv
// Sequencer driving one edge adder switch: op FIFO -> SETUP/HOLD/WAIT/CAPT -> result FIFO.
// Define EDGE_ADDER_CTRL_PERF_EN to add saturating perf_ops/perf_stall/perf_err counters.
module edge_adder_ctrl
  import edge_adder_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_IN    = 2,
  parameter int ADD_LAT   = 1,
  parameter int DEPTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        op_valid_i,
  output logic                        op_ready_o,
  input  logic [DATA_TYPE*NUM_IN-1:0] op_data_i,
  input  logic [2:0]                  op_cmd_i,
  input  logic [SEL_IN-1:0]           op_sel_i,
  output logic                        sw_valid_o,
  output logic [DATA_TYPE*NUM_IN-1:0] sw_data_bus_o,
  output logic                        sw_add_en_o,
  output logic [2:0]                  sw_cmd_o,
  output logic [SEL_IN-1:0]           sw_sel_o,
  input  logic [DATA_TYPE-1:0]        sw_adder_i,
  input  logic [2*DATA_TYPE-1:0]      sw_vn_i,
  input  logic [1:0]                  sw_vn_valid_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [DATA_TYPE-1:0]        res_sum_o,
  output logic [2*DATA_TYPE-1:0]      res_vn_o,
  output logic [1:0]                  res_vn_valid_o,
  output logic                        err_cmd_o
`ifdef EDGE_ADDER_CTRL_PERF_EN
  ,
  output logic [31:0]                 perf_ops_o,
  output logic [31:0]                 perf_stall_o,
  output logic [15:0]                 perf_err_o
`endif
);
  localparam int DW   = DATA_TYPE * NUM_IN;
  localparam int OpW  = DW + 3 + SEL_IN;
  localparam int ResW = 3 * DATA_TYPE + 2;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int CntW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CW-1:0]   DepthC  = CW'(DEPTH);
  localparam logic [CW:0]     DepthV  = (CW + 1)'(DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(ADD_LAT - 1);

  state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              swValid_q, swValid_d;
  logic              swAddEn_q, swAddEn_d;
  logic [DW-1:0]     swData_q, swData_d;
  logic [2:0]        swCmd_q, swCmd_d;
  logic [SEL_IN-1:0] swSel_q, swSel_d;
  logic              errCmd_q;

  logic [OpW-1:0]    opRdata;
  logic [ResW-1:0]   resRdata;
  logic [CW-1:0]     opCount, resCount;
  logic [CW:0]       resUsed;
  logic [DW-1:0]     headData;
  logic [2:0]        headCmd;
  logic [SEL_IN-1:0] headSel;
  logic opPush, opPop, opEmpty, resPush, resPop, inflight, slotFree, canIssue, loadOp, errSet;

  assign op_ready_o = rst_ni && (opCount != DepthC);
  assign opPush     = op_valid_i && op_ready_o;
  assign opEmpty    = (opCount == '0);
  assign {headData, headCmd, headSel} = opRdata;

  sync_fifo #(.W(OpW), .DEPTH(DEPTH)) u_op_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (opPush),
    .pop_i   (opPop),
    .wdata_i ({op_data_i, op_cmd_i, op_sel_i}),
    .rdata_o (opRdata),
    .count_o (opCount)
  );

  sync_fifo #(.W(ResW), .DEPTH(DEPTH)) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (resPush),
    .pop_i   (resPop),
    .wdata_i ({sw_adder_i, sw_vn_i, sw_vn_valid_i}),
    .rdata_o (resRdata),
    .count_o (resCount)
  );

  assign res_valid_o = (resCount != '0);
  assign resPop      = res_valid_o && res_ready_i;
  assign {res_sum_o, res_vn_o, res_vn_valid_o} = resRdata;

  // The op in flight owns one result slot from issue until its capture lands.
  assign inflight = (state_q != ST_IDLE);
  assign resUsed  = {1'b0, resCount} + {{CW{1'b0}}, inflight};
  assign slotFree = (resUsed < DepthV) || resPop;
  assign canIssue = !opEmpty && slotFree;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swValid_d = swValid_q;
    swAddEn_d = swAddEn_q;
    swData_d  = swData_q;
    swCmd_d   = swCmd_q;
    swSel_d   = swSel_q;
    opPop     = 1'b0;
    resPush   = 1'b0;
    loadOp    = 1'b0;
    errSet    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        swValid_d = 1'b0;
        swAddEn_d = 1'b0;
        if (canIssue) begin
          opPop = 1'b1;
          if (is_legal_cmd(headCmd)) loadOp = 1'b1;
          else                       errSet = 1'b1;
        end
      end
      ST_SETUP: begin
        swValid_d = 1'b0;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_d   = '0;
        state_d = (swCmd_q == CMD_ADD) ? ST_WAIT : ST_CAPT;
      end
      ST_WAIT: begin
        if (cnt_q == LastCnt) state_d = ST_CAPT;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_CAPT: begin
        resPush = 1'b1;
        // Illegal heads are left for IDLE so the error path lives in one place.
        if (canIssue && is_legal_cmd(headCmd)) begin
          opPop  = 1'b1;
          loadOp = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          swValid_d = 1'b0;
          swAddEn_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (loadOp) begin
      state_d   = ST_SETUP;
      swValid_d = 1'b1;
      swAddEn_d = (headCmd == CMD_ADD);
      swData_d  = headData;
      swCmd_d   = headCmd;
      swSel_d   = headSel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      swValid_q <= 1'b0;
      swAddEn_q <= 1'b0;
      swData_q  <= '0;
      swCmd_q   <= '0;
      swSel_q   <= '0;
      errCmd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      swValid_q <= swValid_d;
      swAddEn_q <= swAddEn_d;
      swData_q  <= swData_d;
      swCmd_q   <= swCmd_d;
      swSel_q   <= swSel_d;
      errCmd_q  <= errCmd_q | errSet;
    end
  end

  assign sw_valid_o    = swValid_q;
  assign sw_add_en_o   = swAddEn_q;
  assign sw_data_bus_o = swData_q;
  assign sw_cmd_o      = swCmd_q;
  assign sw_sel_o      = swSel_q;
  assign err_cmd_o     = errCmd_q;

`ifdef EDGE_ADDER_CTRL_PERF_EN
  logic [31:0] perfOps_q, perfStall_q;
  logic [15:0] perfErr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perfOps_q   <= '0;
      perfStall_q <= '0;
      perfErr_q   <= '0;
    end else begin
      if (resPush && (perfOps_q != '1)) perfOps_q <= perfOps_q + 1'b1;
      if ((state_q == ST_IDLE) && !opEmpty && !slotFree && (perfStall_q != '1))
        perfStall_q <= perfStall_q + 1'b1;
      if (errSet && (perfErr_q != '1)) perfErr_q <= perfErr_q + 1'b1;
    end
  end

  assign perf_ops_o   = perfOps_q;
  assign perf_stall_o = perfStall_q;
  assign perf_err_o   = perfErr_q;
`endif

endmodule

// File: tb/tb_edge_adder_ctrl.sv
// Bench for edge_adder_ctrl: a behavioural switch, an in-order scoreboard of legal ops,
// and directed scenarios with hand-computed expectations.
module tb_edge_adder_ctrl;
  localparam int AddLat = 1;

  logic         clk = 1'b0;
  logic         rstN;
  logic         opValid, opReady;
  logic [127:0] opData;
  logic [2:0]   opCmd;
  logic [1:0]   opSel;
  logic         swValid, swAddEn;
  logic [127:0] swData;
  logic [2:0]   swCmd;
  logic [1:0]   swSel;
  logic [31:0]  swAdder;
  logic [63:0]  swVn;
  logic [1:0]   swVnValid;
  logic         resValid, resReady;
  logic [31:0]  resSum;
  logic [63:0]  resVn;
  logic [1:0]   resVnValid;
  logic         errCmd;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  int resultsPopped = 0;

  always #5 clk = ~clk;

  edge_adder_ctrl #(
    .DATA_TYPE(32), .NUM_IN(4), .SEL_IN(2), .ADD_LAT(AddLat), .DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .op_valid_i(opValid), .op_ready_o(opReady), .op_data_i(opData),
    .op_cmd_i(opCmd), .op_sel_i(opSel),
    .sw_valid_o(swValid), .sw_data_bus_o(swData), .sw_add_en_o(swAddEn),
    .sw_cmd_o(swCmd), .sw_sel_o(swSel),
    .sw_adder_i(swAdder), .sw_vn_i(swVn), .sw_vn_valid_i(swVnValid),
    .res_valid_o(resValid), .res_ready_i(resReady), .res_sum_o(resSum),
    .res_vn_o(resVn), .res_vn_valid_o(resVnValid), .err_cmd_o(errCmd)
  );

  // FP32 <-> real for normal numbers and zero; operands below are exactly representable.
  function automatic real f32ToReal(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] realToF32(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic isLegal(input logic [2:0] c);
    return (c >= 3'd2) && (c <= 3'd5);
  endfunction

  // What the switch produces for an op: {o_adder, o_vn, o_vn_valid}.
  function automatic logic [97:0] switchOut(input logic [127:0] d, input logic [2:0] c,
                                            input logic [1:0] s);
    logic [1:0]  s1;
    logic [31:0] a, b;
    s1 = s + 2'd1;
    a  = d[32*s +: 32];
    b  = d[32*s1 +: 32];
    case (c)
      3'b010:  return {realToF32(f32ToReal(a) + f32ToReal(b)), 64'd0, 2'b00};
      3'b011:  return {a, 32'd0, a, 2'b01};
      3'b100:  return {a, a, 32'd0, 2'b10};
      default: return {32'd0, b, a, 2'b11};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Switch model: samples at the end of the HOLD cycle; an add sum appears ADD_LAT cycles later.
  logic        holdNext;
  int          latLeft;
  logic [31:0] pendSum;
  logic [97:0] swOut;
  assign swOut = switchOut(swData, swCmd, swSel);

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      holdNext <= 1'b0; latLeft <= 0; pendSum <= '0;
      swAdder <= '0; swVn <= '0; swVnValid <= '0;
    end else begin
      holdNext <= swValid;
      if (holdNext) begin
        swVn      <= swOut[65:2];
        swVnValid <= swOut[1:0];
        if (swCmd == 3'b010) begin
          swAdder <= 32'hBAD0BAD0;
          pendSum <= swOut[97:66];
          latLeft <= AddLat;
        end else begin
          swAdder <= swOut[97:66];
          latLeft <= 0;
        end
      end else if (latLeft > 0) begin
        latLeft <= latLeft - 1;
        if (latLeft == 1) swAdder <= pendSum;
      end
    end
  end

  // Scoreboard: legal accepted ops must be issued once each, held a cycle, and return in order.
  logic [97:0]  expQ[$];
  logic [133:0] issueQ[$];
  logic [133:0] holdExp;
  logic [97:0]  expHead;
  logic         prevSwValid = 1'b0;

  always @(negedge clk) begin
    if (!rstN) begin
      expQ.delete();
      issueQ.delete();
      prevSwValid = 1'b0;
    end else begin
      if (resValid && resReady) begin
        if (expQ.size() == 0) checkOutput("res_unexpected", 160'(resValid), 160'd0);
        else begin
          expHead = expQ.pop_front();
          checkOutput("res_entry", 160'({resSum, resVn, resVnValid}), 160'(expHead));
          resultsPopped++;
        end
      end else if (expQ.size() == 0) begin
        checkOutput("res_valid_empty", 160'(resValid), 160'd0);
      end
      if (prevSwValid) begin
        checkOutput("sw_hold", 160'({swValid, swData, swCmd, swSel, swAddEn}), 160'({1'b0, holdExp}));
      end else if (swValid) begin
        pulseCount++;
        if (issueQ.size() == 0) checkOutput("sw_unexpected", 160'(swValid), 160'd0);
        else begin
          holdExp = issueQ.pop_front();
          checkOutput("sw_setup", 160'({swData, swCmd, swSel, swAddEn}), 160'(holdExp));
        end
      end
      prevSwValid = swValid;
      if (opValid && opReady && isLegal(opCmd)) begin
        expQ.push_back(switchOut(opData, opCmd, opSel));
        issueQ.push_back({opData, opCmd, opSel, opCmd == 3'b010});
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] d, input logic [2:0] c, input logic [1:0] s);
    int n = 0;
    @(posedge clk); #1;
    opData = d; opCmd = c; opSel = s; opValid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!opReady && n < 200);
    if (!opReady) checkOutput("op_accept_timeout", 160'(opReady), 160'd1);
    @(posedge clk); #1;
    opValid = 1'b0;
  endtask

  task automatic waitNeg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitSwValid();
    int n = 0;
    while (!swValid && n < 100) begin @(negedge clk); n++; end
    if (!swValid) checkOutput("sw_valid_timeout", 160'(swValid), 160'd1);
  endtask

  task automatic waitResValid(output int cycles);
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!resValid && cycles < 100);
    if (!resValid) checkOutput("res_valid_timeout", 160'(resValid), 160'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, base, baseRes, basePulse;
    rstN = 1'b0; opValid = 1'b1; opData = 128'h40000000_3F800000; opCmd = 3'b010; opSel = 2'd0;
    resReady = 1'b1;

    // 1: reset holds op_ready low even with an op offered
    waitNeg(2);
    checkOutput("rst_op_ready", 160'(opReady), 160'd0);
    checkOutput("rst_sw_valid", 160'(swValid), 160'd0);
    checkOutput("rst_res_valid", 160'(resValid), 160'd0);
    checkOutput("rst_err_cmd", 160'(errCmd), 160'd0);
    opValid = 1'b0;
    #2 rstN = 1'b1;
    #1 checkOutput("post_rst_op_ready", 160'(opReady), 160'd1);

    // 2: 1.0 + 2.0 add, result 4 cycles after the SETUP cycle
    applyStimulus(128'h0_0_40000000_3F800000, 3'b010, 2'd0);
    waitSwValid();
    checkOutput("add_en_setup", 160'(swAddEn), 160'd1);
    waitResValid(n);
    checkOutput("add_latency", 160'(n), 160'd4);
    checkOutput("add_sum", 160'(resSum), 160'h40400000);
    waitNeg(3);

    // 3: forward ops back-to-back, 3 cycles apart
    applyStimulus(128'h44444444_33333333_22222222_11111111, 3'b011, 2'd2);
    applyStimulus(128'h44444444_33333333_22222222_11111111, 3'b100, 2'd1);
    waitResValid(n);
    checkOutput("fwd1_vn_valid", 160'(resVnValid), 160'd1);
    checkOutput("fwd1_sum", 160'(resSum), 160'h33333333);
    waitResValid(n);
    checkOutput("fwd_gap", 160'(n), 160'd3);
    checkOutput("fwd2_vn_valid", 160'(resVnValid), 160'd2);
    checkOutput("fwd2_sum", 160'(resSum), 160'h22222222);
    waitNeg(3);

    // 4: result FIFO full blocks issue; draining lets the rest complete in order
    @(posedge clk); #1 resReady = 1'b0;
    baseRes = resultsPopped; basePulse = pulseCount;
    applyStimulus(128'h0_0_40800000_3F000000, 3'b010, 2'd0);
    applyStimulus(128'hA_B_C_D, 3'b011, 2'd1);
    applyStimulus(128'hA_B_C_D, 3'b100, 2'd3);
    applyStimulus(128'hA_B_C_D, 3'b101, 2'd2);
    applyStimulus(128'h3F800000_BF800000_0_0, 3'b010, 2'd2);
    applyStimulus(128'h1_2_3_4, 3'b011, 2'd0);
    waitNeg(20);
    checkOutput("full_issued", 160'(pulseCount - basePulse), 160'd4);
    checkOutput("full_res_valid", 160'(resValid), 160'd1);
    checkOutput("full_sw_idle", 160'(swValid), 160'd0);
    checkOutput("full_popped", 160'(resultsPopped - baseRes), 160'd0);
    @(posedge clk); #1 resReady = 1'b1;
    n = 0;
    while ((resultsPopped - baseRes) < 6 && n < 200) begin @(negedge clk); n++; end
    checkOutput("drain_results", 160'(resultsPopped - baseRes), 160'd6);
    checkOutput("drain_issued", 160'(pulseCount - basePulse), 160'd6);
    waitNeg(3);

    // 5: illegal cmd between two legal ops
    checkOutput("err_before", 160'(errCmd), 160'd0);
    baseRes = resultsPopped; basePulse = pulseCount;
    applyStimulus(128'h0_0_40000000_40000000, 3'b010, 2'd0);
    applyStimulus(128'h5_6_7_8, 3'b000, 2'd0);
    applyStimulus(128'h5_6_7_8, 3'b101, 2'd3);
    waitNeg(20);
    checkOutput("err_set", 160'(errCmd), 160'd1);
    checkOutput("err_results", 160'(resultsPopped - baseRes), 160'd2);
    checkOutput("err_pulses", 160'(pulseCount - basePulse), 160'd2);
    applyStimulus(128'h9_9_9_9, 3'b011, 2'd1);
    waitNeg(10);
    checkOutput("err_sticky", 160'(errCmd), 160'd1);

    // 6: reset during WAIT aborts the op
    basePulse = pulseCount;
    applyStimulus(128'h0_0_3F800000_3F800000, 3'b010, 2'd0);
    waitSwValid();
    waitNeg(2);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abort_sw_valid", 160'(swValid), 160'd0);
    checkOutput("abort_sw_cmd", 160'(swCmd), 160'd0);
    checkOutput("abort_sw_data", 160'(swData), 160'd0);
    checkOutput("abort_op_ready", 160'(opReady), 160'd0);
    checkOutput("abort_err", 160'(errCmd), 160'd0);
    waitNeg(2);
    #2 rstN = 1'b1;
    waitNeg(10);
    checkOutput("abort_res_valid", 160'(resValid), 160'd0);
    checkOutput("abort_op_ready_after", 160'(opReady), 160'd1);
    checkOutput("abort_no_reissue", 160'(pulseCount - basePulse), 160'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
